// File: rtl/fixed_acc_if.sv
// Beat-in / result-out handshake bundle for the Q8.8 group accumulator.
// Slave is the accumulator; master is whoever drives beats and drains results.
interface fixed_acc_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ovf;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_ovf, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, in_ovf, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_count
    );
endinterface

// File: rtl/fixed_acc.sv
// Unsigned Q8.8 group accumulator: result valid 1 cycle after last beat, saturating, sticky ovf.
// Result held stable while out_ready is low; no beats accepted while a result is pending.
module fixed_acc #(
    parameter int WIDTH = 16,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    fixed_acc_if.slave bus
);
    localparam int ACC_W = WIDTH + GUARD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_count;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_sticky_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_sum    = {1'b0, r_acc} + {{(GUARD + 1){1'b0}}, bus.in_data};

    // Next-state values for the beat being accepted; the first beat of a group reloads.
    always_comb begin
        w_acc_nxt    = {{GUARD{1'b0}}, bus.in_data};
        w_sticky_nxt = bus.in_ovf;
        w_cnt_nxt    = {{(CNT_W - 1){1'b0}}, 1'b1};
        if (r_state == S_ACC) begin
            w_acc_nxt    = w_sum[ACC_W-1:0];
            w_sticky_nxt = r_sticky | bus.in_ovf | w_sum[ACC_W];
            w_cnt_nxt    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        end
        w_ovf = w_sticky_nxt | (|w_acc_nxt[ACC_W-1:WIDTH]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        r_acc    <= w_acc_nxt;
                        r_sticky <= w_sticky_nxt;
                        r_cnt    <= w_cnt_nxt;
                        if (bus.in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_ovf ? {WIDTH{1'b1}} : w_acc_nxt[WIDTH-1:0];
                            r_out_ovf   <= w_ovf;
                            r_out_count <= w_cnt_nxt;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    // in_ready reopens only after the handshake edge, so no beat overlaps it.
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_count = r_out_count;
endmodule
